// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, in-order imem requests, instruction FIFO toward decode, redirect flush.
// Optional opcode legality flag on the decode port is built only with IFU_ILLEGAL_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic        id_illegal
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [31:0]   instr_buf_q [FIFO_DEPTH];
    logic [31:0]   instr_buf_d [FIFO_DEPTH];
    logic [31:0]   pc_buf_q    [FIFO_DEPTH];
    logic [31:0]   pc_buf_d    [FIFO_DEPTH];
    logic [31:0]   req_pc_q    [FIFO_DEPTH];
    logic [31:0]   req_pc_d    [FIFO_DEPTH];

    logic        req_fire_s, resp_drop_s, push_s, pop_s;
    logic [31:0] redirect_word_s;

    // Issue is capped so in-flight plus buffered entries never exceed the FIFO
    assign imem_req_valid = !reset && !redirect_valid &&
                            ((outstanding_q + fifo_count_q) < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign id_valid       = (fifo_count_q != CNT_ZERO);
    assign id_instr       = instr_buf_q[rd_ptr_q];
    assign id_pc          = pc_buf_q[rd_ptr_q];
    assign id_opcode      = id_instr[6:0];

    // Next-state for PC, request-PC tracking, drop counter and instruction FIFO
    always_comb begin
        req_fire_s      = imem_req_valid && imem_req_ready;
        resp_drop_s     = (drop_cnt_q != CNT_ZERO);
        push_s          = imem_resp_valid && !resp_drop_s && !redirect_valid;
        pop_s           = id_valid && id_ready;
        redirect_word_s = redirect_pc & 32'hFFFF_FFFC;
        instr_buf_d     = instr_buf_q;
        pc_buf_d        = pc_buf_q;
        req_pc_d        = req_pc_q;
        req_wr_d        = req_wr_q;
        req_rd_d        = req_rd_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        fifo_count_d    = fifo_count_q;

        if (redirect_valid) begin
            pc_d = redirect_word_s;
        end else if (req_fire_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        if (req_fire_s) begin
            req_pc_d[req_wr_q] = pc_q;
            req_wr_d           = req_wr_q + PTR_ONE;
        end else begin
            req_wr_d = req_wr_q;
        end

        outstanding_d = outstanding_q + (req_fire_s ? CNT_ONE : CNT_ZERO)
                                      - (imem_resp_valid ? CNT_ONE : CNT_ZERO);

        // Everything still in flight after a redirect belongs to the old stream
        if (redirect_valid) begin
            drop_cnt_d = outstanding_d;
        end else if (imem_resp_valid && resp_drop_s) begin
            drop_cnt_d = drop_cnt_q - CNT_ONE;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (redirect_valid) begin
            wr_ptr_d     = PTR_ZERO;
            rd_ptr_d     = PTR_ZERO;
            fifo_count_d = CNT_ZERO;
        end else begin
            if (push_s) begin
                instr_buf_d[wr_ptr_q] = imem_resp_data;
                pc_buf_d[wr_ptr_q]    = req_pc_q[req_rd_q];
                wr_ptr_d              = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            fifo_count_d = fifo_count_q + (push_s ? CNT_ONE : CNT_ZERO)
                                        - (pop_s ? CNT_ONE : CNT_ZERO);
        end

        if (imem_resp_valid) begin
            req_rd_d = req_rd_q + PTR_ONE;
        end else begin
            req_rd_d = req_rd_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= CNT_ZERO;
            fifo_count_q  <= CNT_ZERO;
            drop_cnt_q    <= CNT_ZERO;
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            req_wr_q      <= PTR_ZERO;
            req_rd_q      <= PTR_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_buf_q[i] <= 32'h0000_0000;
                pc_buf_q[i]    <= 32'h0000_0000;
                req_pc_q[i]    <= 32'h0000_0000;
            end
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            req_wr_q      <= req_wr_d;
            req_rd_q      <= req_rd_d;
            instr_buf_q   <= instr_buf_d;
            pc_buf_q      <= pc_buf_d;
            req_pc_q      <= req_pc_d;
        end
    end

`ifdef IFU_ILLEGAL_CHECK_EN
    logic opcode_legal_s;

    // Opcodes the downstream control decoder understands
    always_comb begin
        case (id_opcode)
            7'b0110011, 7'b0000011, 7'b0100011,
            7'b0010011, 7'b1100011: opcode_legal_s = 1'b1;
            default:                opcode_legal_s = 1'b0;
        endcase
    end

    assign id_illegal = id_valid && !opcode_legal_s;
`else
    assign id_illegal = 1'b0;
`endif

    instr_fetch_unit_chk #(.CW(CW)) u_chk (
        .clk        (clk),
        .reset      (reset),
        .resp_valid (imem_resp_valid),
        .fifo_count (fifo_count_q),
        .depth      (DEPTH_C)
    );
endmodule

// Protocol checker: a response must never arrive while the instruction FIFO is full.
module instr_fetch_unit_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          resp_valid,
    input logic [CW-1:0] fifo_count,
    input logic [CW-1:0] depth
);
    a_no_resp_when_full: assert property (@(posedge clk) disable iff (reset)
        !(resp_valid && (fifo_count == depth)));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order fetch, backpressure, redirects, PC wrap, opcode flag.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_ready, imem_resp_valid, redirect_valid, id_ready;
    logic [31:0] imem_resp_data, redirect_pc;
    logic        imem_req_valid, id_valid, id_illegal;
    logic [31:0] imem_req_addr, id_instr, id_pc;
    logic [6:0]  id_opcode;
    logic        w_req_valid, w_id_valid, w_id_illegal;
    logic [31:0] w_req_addr, w_id_instr, w_id_pc;
    logic [6:0]  w_id_opcode;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int first_fire = -1;
    int first_valid = -1;
    logic [31:0] fire_q[$], wfire_q[$], mem_addr_q[$], del_pc[$], del_instr[$];
    logic [31:0] del_opc[$], del_ill[$];
    int          mem_due_q[$];
    logic        exp_ill;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode),
        .id_illegal(id_illegal)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(w_id_valid), .id_ready(id_ready),
        .id_instr(w_id_instr), .id_pc(w_id_pc), .id_opcode(w_id_opcode),
        .id_illegal(w_id_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0400: mem_word = 32'h0000_0033;
            32'h0000_0404: mem_word = 32'h0000_007F;
            default:       mem_word = a ^ 32'h1357_0013;
        endcase
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        at = (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_logs();
        fire_q.delete(); wfire_q.delete(); mem_addr_q.delete(); mem_due_q.delete();
        del_pc.delete(); del_instr.delete(); del_opc.delete(); del_ill.delete();
        first_fire = -1;
        first_valid = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        imem_req_ready = 1'b1;
        clear_logs();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rst_id_instr", id_instr, 32'h0);
        check_eq("rst_id_pc", id_pc, 32'h0);
        check_eq("rst_id_illegal", {31'd0, id_illegal}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        cyc = 0;
    endtask

    // One clock: memory model drives any due response, inputs applied, outputs logged
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic idr);
        @(negedge clk);
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = idr;
        #1;
        if (imem_req_valid && imem_req_ready) begin
            fire_q.push_back(imem_req_addr);
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + lat);
            if (first_fire < 0) first_fire = cyc;
        end
        if (w_req_valid && imem_req_ready) wfire_q.push_back(w_req_addr);
        if (id_valid && first_valid < 0) first_valid = cyc;
        if (id_valid && id_ready) begin
            del_pc.push_back(id_pc);
            del_instr.push_back(id_instr);
            del_opc.push_back({25'd0, id_opcode});
            del_ill.push_back({31'd0, id_illegal});
        end
        cyc++;
    endtask

    initial begin
`ifdef IFU_ILLEGAL_CHECK_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        // In-order streaming with 1-cycle memory, plus PC wrap on the second instance
        lat = 1;
        do_reset();
        repeat (10) cycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) check_eq("t1_req_addr", at(fire_q, i), 32'(i * 4));
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_id_pc", at(del_pc, i), 32'(i * 4));
            check_eq("t1_id_instr", at(del_instr, i), mem_word(32'(i * 4)));
            check_eq("t1_id_opcode", at(del_opc, i), {25'd0, mem_word(32'(i * 4)) & 32'h7F});
        end
        check_eq("t1_first_latency", 32'(first_valid - first_fire), 32'd2);
        check_eq("t5_wrap_addr0", at(wfire_q, 0), 32'hFFFF_FFFC);
        check_eq("t5_wrap_addr1", at(wfire_q, 1), 32'h0000_0000);

        // Backpressure: two requests fill the FIFO, head holds steady
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            if (i >= 2) begin
                check_eq("t2_hold_pc", id_pc, 32'h0);
                check_eq("t2_hold_instr", id_instr, mem_word(32'h0));
            end
        end
        check_eq("t2_num_req", 32'(fire_q.size()), 32'd2);
        check_eq("t2_req_valid_low", {31'd0, imem_req_valid}, 32'd0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        check_eq("t2_del0", at(del_pc, 0), 32'h0);
        check_eq("t2_del1", at(del_pc, 1), 32'h4);
        check_eq("t2_resume_addr", at(fire_q, 2), 32'h8);

        // Redirect with two requests still in flight (3-cycle memory)
        lat = 3;
        do_reset();
        repeat (2) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h0000_0100, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check_eq("t3_fifo_empty", {31'd0, id_valid}, 32'd0);
        repeat (8) cycle(1'b0, 32'h0, 1'b1);
        check_eq("t3_next_addr", at(fire_q, 2), 32'h0000_0100);
        check_eq("t3_first_pc", at(del_pc, 0), 32'h0000_0100);
        check_eq("t3_first_instr", at(del_instr, 0), mem_word(32'h0000_0100));

        // Redirect coinciding with a response and a decode handshake
        lat = 1;
        do_reset();
        repeat (2) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h0000_0203, 1'b1);
        check_eq("t4_hs_count", 32'(del_pc.size()), 32'd1);
        check_eq("t4_hs_pc", at(del_pc, 0), 32'h0);
        repeat (5) cycle(1'b0, 32'h0, 1'b1);
        check_eq("t4_next_addr", at(fire_q, 2), 32'h0000_0200);
        check_eq("t4_after_pc", at(del_pc, 1), 32'h0000_0200);

        // Request masking in the redirect cycle, then opcode legality flag
        do_reset();
        cycle(1'b1, 32'h0000_0400, 1'b1);
        check_eq("t6_req_masked", {31'd0, imem_req_valid}, 32'd0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        check_eq("t6_first_addr", at(fire_q, 0), 32'h0000_0400);
        check_eq("t6_pc0", at(del_pc, 0), 32'h0000_0400);
        check_eq("t6_legal", at(del_ill, 0), 32'd0);
        check_eq("t6_pc1", at(del_pc, 1), 32'h0000_0404);
        check_eq("t6_opcode", at(del_opc, 1), 32'h0000_007F);
        check_eq("t6_illegal", at(del_ill, 1), {31'd0, exp_ill});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
